shift_add_mult_ctrl: RTL and testbench

- Sequential 16x16 unsigned multiplier built around one shared 16-bit two-level CLA adder instance.
- Controller FSM sequences 16 shift-add steps through the adder and accumulates a 32-bit product.
- Uses a valid/ready handshake on both input and output sides.
- Small-area alternative to the Wallace-tree multiplier; same operand/product widths, so the two are interchangeable behind the handshake.

---
 rtl/shift_add_mult_ctrl.sv | 146 ++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 16x16 unsigned shift-add multiplier with valid/ready handshakes.
// A single 16-bit two-level carry-lookahead adder is reused on every step.
module shift_add_mult_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

    state_t      state_r, state_nxt;
    logic [3:0]  cnt_r, cnt_nxt;
    logic [15:0] acc_hi_r, acc_hi_nxt;
    logic [15:0] acc_lo_r, acc_lo_nxt;
    logic [15:0] mcand_r, mcand_nxt;
    logic [31:0] product_r, product_nxt;
    logic        out_valid_r, out_valid_nxt;
    logic [15:0] addend_s;
    logic [16:0] sum_s;
    logic        accept_s;

    // Two-level CLA: 4-bit groups, group generate/propagate resolved by a second lookahead level.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = 1'b0;
        gc[1] = gg[0];
        gc[2] = gg[1] | (gp[1] & gg[0]);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 1; i < 4; i++) begin
                c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
            end
        end
        return {gc[4], p ^ c};
    endfunction

    assign in_ready  = (state_r == IDLE) && !rst;
    assign accept_s  = in_valid && in_ready;
    assign busy      = (state_r == RUN);
    assign out_valid = out_valid_r;
    assign product   = product_r;
    assign addend_s  = acc_lo_r[0] ? mcand_r : 16'h0000;
    assign sum_s     = cla16(acc_hi_r, addend_s);

    // Next-state and datapath update for the controller.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        acc_hi_nxt    = acc_hi_r;
        acc_lo_nxt    = acc_lo_r;
        mcand_nxt     = mcand_r;
        product_nxt   = product_r;
        out_valid_nxt = out_valid_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    mcand_nxt  = a;
                    acc_lo_nxt = b;
                    acc_hi_nxt = 16'h0000;
                    cnt_nxt    = 4'd0;
                    if (SKIP_ZERO && ((a == 16'h0000) || (b == 16'h0000))) begin
                        product_nxt = 32'h0000_0000;
                        state_nxt   = SKIP;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            SKIP: begin
                state_nxt     = DONE;
                out_valid_nxt = 1'b1;
            end
            RUN: begin
                // The carry out of the adder shifts into bit 31, so no overflow is lost.
                {acc_hi_nxt, acc_lo_nxt} = {sum_s, acc_lo_r[15:1]};
                cnt_nxt = cnt_r + 4'd1;
                if (cnt_r == 4'd15) begin
                    product_nxt   = {sum_s, acc_lo_r[15:1]};
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            acc_hi_r    <= 16'h0000;
            acc_lo_r    <= 16'h0000;
            mcand_r     <= 16'h0000;
            product_r   <= 32'h0000_0000;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            acc_hi_r    <= acc_hi_nxt;
            acc_lo_r    <= acc_lo_nxt;
            mcand_r     <= mcand_nxt;
            product_r   <= product_nxt;
            out_valid_r <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: zero-skip and full-latency instances.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;
    logic        busy;

    logic        in_valid0 = 1'b0;
    logic        in_ready0;
    logic        out_valid0;
    logic        out_ready0 = 1'b1;
    logic [31:0] product0;
    logic        busy0;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [31:0] exp_q[$];

    shift_add_mult_ctrl #(.SKIP_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    shift_add_mult_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready0),
        .product(product0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for the accept edge, and record the expected product.
    task automatic send(input logic [15:0] av, input logic [15:0] bv);
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back({16'h0000, av} * {16'h0000, bv});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'd3;
        b = 16'd4;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ov=%0b busy=%0b want 0/0", out_valid, busy);
        end
        e = 32'h0;
        checks++;
        if (product !== e) begin errors++; $display("FAIL reset_product got %h want %h", product, e); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int n = 0;
        int busy_n = 0;
        int rdy_n = 0;
        logic [31:0] e;
        out_ready = 1'b1;
        send(16'd10, 16'd10);
        while (!out_valid && n < 100) begin
            if (busy) busy_n++;
            if (in_ready) rdy_n++;
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", n); end
        checks++;
        if (busy_n !== 16 || rdy_n !== 0) begin
            errors++; $display("FAIL basic_busy got busy=%0d ready=%0d want 16/0", busy_n, rdy_n);
        end
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin errors++; $display("FAIL basic_product got %h want %h", product, e); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_return got ov=%0b rdy=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_max();
        int n;
        logic [31:0] e;
        logic [15:0] av [2] = '{16'hFFFF, 16'd20000};
        logic [15:0] bv [2] = '{16'hFFFF, 16'd25555};
        logic [31:0] ref_v [2] = '{32'hFFFE_0001, 32'h1E76_C460};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(av[i], bv[i]);
            wait_valid(n);
            checks++;
            if (n !== 16) begin errors++; $display("FAIL max_latency%0d got %0d want 16", i, n); end
            e = exp_q.pop_front();
            checks++;
            if (product !== e || product !== ref_v[i]) begin
                errors++; $display("FAIL max_product%0d got %h want %h", i, product, ref_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int stale = 0;
        logic [31:0] e;
        out_ready = 1'b1;
        send(16'd150, 16'd130);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_flags got rdy=%0b busy=%0b ov=%0b want 0/0/0", in_ready, busy, out_valid);
        end
        e = 32'h0;
        checks++;
        if (product !== e) begin errors++; $display("FAIL midrun_product got %h want %h", product, e); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) stale++;
            tick();
        end
        checks++;
        if (stale !== 0) begin errors++; $display("FAIL midrun_stale got %0d want 0", stale); end
        send(16'd3, 16'd5);
        wait_valid(n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL midrun_latency got %0d want 16", n); end
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin errors++; $display("FAIL midrun_product2 got %h want %h", product, e); end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        int bad = 0;
        logic [31:0] e;
        out_ready = 1'b0;
        send(16'd7, 16'd9);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin errors++; $display("FAIL bp_product got %h want %h", product, e); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = 16'd1 + 16'(i);
            b = 16'd2;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || product !== e) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== e) begin
            errors++; $display("FAIL bp_release got ov=%0b rdy=%0b p=%h want 0/1/%h", out_valid, in_ready, product, e);
        end
    endtask

    task automatic test_zero_skip();
        int n;
        logic [31:0] e;
        out_ready = 1'b1;
        send(16'h0000, 16'h1234);
        wait_valid(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL zskip_latency got %0d want 1", n); end
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin errors++; $display("FAIL zskip_product got %h want %h", product, e); end
        tick();
        checks++;
        if (in_ready0 !== 1'b1) begin errors++; $display("FAIL zfull_ready got %0b want 1", in_ready0); end
        a = 16'h0000;
        b = 16'h1234;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        n = 0;
        while (!out_valid0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL zfull_latency got %0d want 16", n); end
        e = 32'h0;
        checks++;
        if (product0 !== e) begin errors++; $display("FAIL zfull_product got %h want %h", product0, e); end
        tick();
    endtask

    task automatic test_random();
        int n;
        int hs0;
        int stall;
        int bad_lat = 0;
        int bad_hold = 0;
        int bad_prod = 0;
        logic [15:0] av, bv;
        logic [31:0] e;
        hs0 = hs_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if ($urandom_range(15) == 0) av = ($urandom_range(1) == 0) ? 16'h0000 : 16'hFFFF;
            if ($urandom_range(15) == 0) bv = ($urandom_range(1) == 0) ? 16'h0000 : 16'hFFFF;
            send(av, bv);
            wait_valid(n);
            if (n != (((av == 16'h0) || (bv == 16'h0)) ? 1 : 16)) bad_lat++;
            e = exp_q.pop_front();
            stall = $urandom_range(3);
            for (int s = 0; s < stall; s++) begin
                if (out_valid !== 1'b1 || product !== e) bad_hold++;
                tick();
            end
            if (product !== e) begin
                bad_prod++;
                if (bad_prod <= 5) $display("FAIL rand_product a=%h b=%h got %h want %h", av, bv, product, e);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        tick();
        checks++;
        if (bad_prod !== 0) begin errors++; $display("FAIL rand_products got %0d wrong want 0", bad_prod); end
        checks++;
        if (bad_lat !== 0) begin errors++; $display("FAIL rand_latency got %0d wrong want 0", bad_lat); end
        checks++;
        if (bad_hold !== 0) begin errors++; $display("FAIL rand_hold got %0d unstable want 0", bad_hold); end
        checks++;
        if ((hs_cnt - hs0) !== 1000 || exp_q.size() !== 0) begin
            errors++; $display("FAIL rand_handshakes got %0d left=%0d want 1000/0", hs_cnt - hs0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_reset_mid_run();
        test_backpressure();
        test_zero_skip();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
